logic_gate_unit: RTL



---
 rtl/logic_gate_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/logic_gate_unit.sv
// W-bit registered bitwise logic unit with valid/ready and packet accumulate.
// Define LOGIC_GATE_UNIT_POPCOUNT_EN to add the registered y_ones output.
module logic_gate_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         acc_en,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         y_zero,
  output logic         y_any
`ifdef LOGIC_GATE_UNIT_POPCOUNT_EN
  ,
  output logic [$clog2(W+1)-1:0] y_ones
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  function automatic logic [W-1:0] f_gate(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] z
  );
    case (o)
      3'd0:    f_gate = x & z;
      3'd1:    f_gate = x | z;
      3'd2:    f_gate = x ^ z;
      3'd3:    f_gate = ~(x & z);
      3'd4:    f_gate = ~(x | z);
      3'd5:    f_gate = ~(x ^ z);
      3'd6:    f_gate = ~x;
      default: f_gate = x;
    endcase
  endfunction

  // Inverting ops fold with their base operator; NOT/PASS keep the last a.
  function automatic logic [W-1:0] f_base(
    input logic [2:0]   o,
    input logic [W-1:0] acc,
    input logic [W-1:0] x
  );
    case (o)
      3'd0, 3'd3: f_base = acc & x;
      3'd1, 3'd4: f_base = acc | x;
      3'd2, 3'd5: f_base = acc ^ x;
      default:    f_base = x;
    endcase
  endfunction

  logic [0:0]   r_state;
  logic [W-1:0] r_acc;
  logic [2:0]   r_op;
  logic         r_valid;
  logic [W-1:0] r_y;
  logic         r_zero;
  logic         r_any;

  logic         w_fire;
  logic         w_idle;
  logic         w_single;
  logic         w_emit;
  logic         w_inv;
  logic [2:0]   w_op_eff;
  logic [W-1:0] w_acc_nxt;
  logic [W-1:0] w_res;

  assign in_ready  = !r_valid || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign w_idle    = (r_state == S_IDLE);
  assign w_single  = w_idle && !acc_en;
  assign w_emit    = w_fire && (w_single || in_last);
  assign w_op_eff  = w_idle ? op : r_op;
  assign w_acc_nxt = w_idle ? a : f_base(r_op, r_acc, a);
  assign w_inv     = (w_op_eff >= 3'd3) && (w_op_eff <= 3'd6);

  always_comb begin
    w_res = w_inv ? ~w_acc_nxt : w_acc_nxt;
    if (w_single) w_res = f_gate(op, a, b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_op    <= '0;
      r_valid <= 1'b0;
      r_y     <= '0;
      r_zero  <= 1'b1;
      r_any   <= 1'b0;
    end else begin
      if (w_fire && !w_single) begin
        r_acc   <= w_acc_nxt;
        r_state <= in_last ? S_IDLE : S_ACC;
        if (w_idle) r_op <= op;
      end
      if (w_emit) begin
        r_valid <= 1'b1;
        r_y     <= w_res;
        r_zero  <= ~|w_res;
        r_any   <= |w_res;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign y         = r_y;
  assign y_zero    = r_zero;
  assign y_any     = r_any;

`ifdef LOGIC_GATE_UNIT_POPCOUNT_EN
  localparam int CW = $clog2(W+1);

  function automatic logic [CW-1:0] f_pop(input logic [W-1:0] x);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n = n + int'(x[i]);
    f_pop = CW'(n);
  endfunction

  logic [CW-1:0] r_ones;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ones <= '0;
    else if (w_emit) r_ones <= f_pop(w_res);
  end

  assign y_ones = r_ones;
`endif

endmodule
